// File: rtl/partition_sweep_pkg.sv
// rtl/partition_sweep_pkg.sv - shared types and width helpers for the partition truth-table sweeper
package partition_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_EMIT,
    ST_DONE
  } sweep_state_e;

  // Widest partition output the popcount helper has to cover.
  localparam int POP_W = 32;

  function automatic int err_cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int err_bits_w(input int n_in, input int n_out);
    return n_in + $clog2(n_out + 1);
  endfunction

  function automatic int settle_w(input int settle_cyc);
    return (settle_cyc > 1) ? $clog2(settle_cyc) : 1;
  endfunction

  function automatic logic [5:0] popcount(input logic [POP_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + {5'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/partition_tt_sweeper.sv
// rtl/partition_tt_sweeper.sv - exhaustive truth-table sweeper for one combinational partition
// Optional golden-reference mismatch counters are enabled by PARTITION_TT_GOLDEN_CMP_EN.
module partition_tt_sweeper
  import partition_sweep_pkg::*;
#(
  parameter int N_IN       = 6,
  parameter int N_OUT      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  pi_o,
  input  logic [N_OUT-1:0] po_i,
  output logic             tt_valid,
  input  logic             tt_ready,
  output logic [N_IN-1:0]  tt_index,
  output logic [N_OUT-1:0] tt_data
`ifdef PARTITION_TT_GOLDEN_CMP_EN
  ,
  input  logic [N_OUT-1:0]                     ref_po_i,
  output logic [err_cnt_w(N_IN)-1:0]           err_cnt,
  output logic [err_bits_w(N_IN, N_OUT)-1:0]   err_bits
`endif
);

  localparam int                CNT_W       = settle_w(SETTLE_CYC);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]   PI_LAST     = '1;

  sweep_state_e     state, state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             load, capture, accept;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt = ST_SETTLE;
          load      = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (settle_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // abort outranks a simultaneous handshake
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (tt_valid && tt_ready) begin
          accept    = 1'b1;
          state_nxt = (pi_o == PI_LAST) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      pi_o       <= '0;
      tt_valid   <= 1'b0;
      tt_index   <= '0;
      tt_data    <= '0;
    end else begin
      state    <= state_nxt;
      tt_valid <= (state_nxt == ST_EMIT);
      if (load) begin
        pi_o <= '0;
      end else if (accept && state_nxt == ST_SETTLE) begin
        pi_o <= pi_o + N_IN'(1);
      end
      // reload on every entry into SETTLE, count down while holding
      if (state_nxt == ST_SETTLE && state != ST_SETTLE) begin
        settle_cnt <= SETTLE_LAST;
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt - CNT_W'(1);
      end
      if (capture) begin
        tt_data  <= po_i;
        tt_index <= pi_o;
      end
    end
  end

  assign busy = (state == ST_SETTLE) || (state == ST_EMIT);
  assign done = (state == ST_DONE);

`ifdef PARTITION_TT_GOLDEN_CMP_EN
  localparam int ERRC_W = err_cnt_w(N_IN);
  localparam int ERRB_W = err_bits_w(N_IN, N_OUT);

  logic [N_OUT-1:0] diff;
  assign diff = po_i ^ ref_po_i;

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      err_cnt  <= '0;
      err_bits <= '0;
    end else if (capture && diff != '0) begin
      err_cnt  <= err_cnt + ERRC_W'(1);
      err_bits <= err_bits + ERRB_W'(popcount(POP_W'(diff)));
    end
  end
`endif

endmodule

// File: tb/tb_partition_tt_sweeper.sv
// tb/tb_partition_tt_sweeper.sv - randomized self-checking bench for partition_tt_sweeper
module tb_partition_tt_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start, abort, ready, busy, done, valid;
  logic [5:0] pi  [2];
  logic [5:0] idx [2];
  logic [3:0] data[2];
  logic [3:0] po_a, po_b, d1, d2;
  logic       inject;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] part_f(input logic [5:0] p);
    return {1'b0, p[5:3]} + {1'b0, p[2:0]};
  endfunction

  // instance 0 sees the partition directly, instance 1 through two register stages
  assign po_a = part_f(pi[0]) ^ {3'b000, inject & pi[0][0]};
  always_ff @(posedge clk) begin
    d1 <= part_f(pi[1]);
    d2 <= d1;
  end
  assign po_b = d2;

`ifdef PARTITION_TT_GOLDEN_CMP_EN
  logic [6:0] err_cnt_a, err_cnt_b;
  logic [8:0] err_bits_a, err_bits_b;
`endif

  partition_tt_sweeper #(.N_IN(6), .N_OUT(4), .SETTLE_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .busy(busy[0]), .done(done[0]), .pi_o(pi[0]), .po_i(po_a),
    .tt_valid(valid[0]), .tt_ready(ready[0]), .tt_index(idx[0]), .tt_data(data[0])
`ifdef PARTITION_TT_GOLDEN_CMP_EN
    , .ref_po_i(part_f(pi[0])), .err_cnt(err_cnt_a), .err_bits(err_bits_a)
`endif
  );

  partition_tt_sweeper #(.N_IN(6), .N_OUT(4), .SETTLE_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .busy(busy[1]), .done(done[1]), .pi_o(pi[1]), .po_i(po_b),
    .tt_valid(valid[1]), .tt_ready(ready[1]), .tt_index(idx[1]), .tt_data(data[1])
`ifdef PARTITION_TT_GOLDEN_CMP_EN
    , .ref_po_i(po_b), .err_cnt(err_cnt_b), .err_bits(err_bits_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_data(input int s, input int i);
    logic [5:0] p;
    logic [3:0] r;
    p = i[5:0];
    r = part_f(p);
    if (s == 0 && inject && p[0]) r[0] = ~r[0];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready high, 1 ready one cycle in three, 2 random ready
  // stop_kind: 0 none, 1 reset at entry, 2 abort in SETTLE of pattern, 3 abort with handshake in EMIT
  task automatic sweep(input int s, input int rmode, input int stop_kind, input int stop_at);
    int         n_acc, cyc, settle_n;
    bit         stall, fired, saw_done;
    logic [5:0] p_idx, p_pi;
    logic [3:0] p_data;
    settle_n = (s == 0) ? 1 : 3;
    n_acc = 0; cyc = 0; stall = 0; fired = 0; saw_done = 0;
    p_idx = '0; p_pi = '0; p_data = '0;
    start[s] = 1'b1;
    step();
    start[s] = 1'b0;
    check("start_busy", busy[s], 1);
    check("start_pi", pi[s], 0);
    while (cyc < 3000 && !fired && !saw_done) begin
      if (done[s]) begin
        saw_done = 1;
        check("done_entries", n_acc, 64);
        if (rmode == 0) check("sweep_len", cyc, 64 * (settle_n + 1));
      end else begin
        if (stall) begin
          check("stall_valid", valid[s], 1);
          check("stall_index", idx[s], p_idx);
          check("stall_data", data[s], p_data);
          check("stall_pi", pi[s], p_pi);
        end
        if (valid[s]) begin
          check("entry_index", idx[s], n_acc);
          check("entry_data", data[s], exp_data(s, n_acc));
          check("entry_pi", pi[s], n_acc);
          if (!inject && n_acc == 29) check("entry29_data", data[s], 4'b1000);
          if (!inject && n_acc == 63) check("entry63_data", data[s], 4'b1110);
        end
        case (rmode)
          0:       ready[s] = 1'b1;
          1:       ready[s] = (cyc % 3 == 0);
          default: ready[s] = 1'($urandom_range(0, 1));
        endcase
        start[s] = 1'($urandom_range(0, 1));
        if (stop_kind == 1 && valid[s] && idx[s] == stop_at) begin
          rst_n = 1'b0; fired = 1;
        end
        if (stop_kind == 2 && !valid[s] && pi[s] == stop_at) begin
          abort[s] = 1'b1; fired = 1;
        end
        if (stop_kind == 3 && valid[s] && idx[s] == stop_at) begin
          abort[s] = 1'b1; ready[s] = 1'b1; fired = 1;
        end
        if (fired) start[s] = 1'b0;
        stall  = valid[s] && !ready[s];
        p_idx  = idx[s];
        p_data = data[s];
        p_pi   = pi[s];
        if (valid[s] && ready[s] && !fired) n_acc++;
        step();
        cyc++;
      end
    end
    start[s] = 1'b0;
    ready[s] = 1'b0;
    check("sweep_ended", {31'b0, saw_done | fired}, 1);
    if (fired) begin
      rst_n    = 1'b1;
      abort[s] = 1'b0;
      check("stop_busy", busy[s], 0);
      check("stop_valid", valid[s], 0);
      check("stop_done", done[s], 0);
      if (stop_kind == 1) begin
        check("rst_pi", pi[s], 0);
        check("rst_index", idx[s], 0);
        check("rst_data", data[s], 0);
      end
      for (int k = 0; k < 4; k++) begin
        step();
        check("stop_no_done", done[s], 0);
        check("stop_idle", busy[s], 0);
      end
    end else if (saw_done) begin
      step();
      check("done_one_cycle", done[s], 0);
      check("post_done_busy", busy[s], 0);
      check("post_done_pi", pi[s], 63);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = '0; abort = '0; ready = '0; inject = 1'b0;
    repeat (2) step();
    for (int s = 0; s < 2; s++) begin
      check("rst_busy", busy[s], 0);
      check("rst_done", done[s], 0);
      check("rst_valid", valid[s], 0);
      check("rst_pi", pi[s], 0);
      check("rst_index", idx[s], 0);
      check("rst_data", data[s], 0);
    end
    rst_n = 1'b1;

    start[0] = 1'b1; abort[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("start_abort_idle", busy[0], 0);
    step();
    abort[0] = 1'b0;
    check("abort_idle_noop", busy[0], 0);
    check("abort_idle_valid", valid[0], 0);
    ready[0] = 1'b1;
    step();
    ready[0] = 1'b0;
    check("ready_idle_valid", valid[0], 0);

    sweep(0, 0, 0, 0);
    sweep(0, 1, 0, 0);
    sweep(0, 2, 1, 20);
    sweep(0, 0, 0, 0);
    sweep(0, 2, 2, 10);
    sweep(0, 2, 3, 10);
    sweep(0, 2, 0, 0);
    sweep(1, 0, 0, 0);
    sweep(1, 2, 0, 0);

`ifdef PARTITION_TT_GOLDEN_CMP_EN
    sweep(0, 0, 0, 0);
    check("gold_clean_cnt", err_cnt_a, 0);
    check("gold_clean_bits", err_bits_a, 0);
    inject = 1'b1;
    sweep(0, 2, 0, 0);
    check("gold_fault_cnt", err_cnt_a, 32);
    check("gold_fault_bits", err_bits_a, 32);
    inject = 1'b0;
    sweep(0, 0, 0, 0);
    check("gold_cleared_cnt", err_cnt_a, 0);
    check("gold_cleared_bits", err_bits_a, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
